// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues 1-cycle synchronous ram reads and
// buffers returned words in a 2-entry FIFO with redirect flush and fault trapping.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 14
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_data,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              trap
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_TRAP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] fifo_data_q [2];
    logic [31:0] fifo_pc_q   [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;

    logic       pop;
    logic       flush;
    logic       wr_en;
    logic       issue;
    logic [2:0] occupancy;

    function automatic logic pc_legal(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && ((pc >> ADDR_W) == 32'd0);
    endfunction

    assign i_addr     = fetch_pc_q[ADDR_W-1:0];
    assign inst       = fifo_data_q[rd_ptr_q];
    assign inst_pc    = fifo_pc_q[rd_ptr_q];
    assign inst_valid = (count_q != 2'd0) && (state_q != ST_TRAP);
    assign trap       = (state_q == ST_TRAP);

    assign pop   = inst_valid & inst_ready;
    assign flush = redirect && (state_q != ST_TRAP);
    // A squashed in-flight read returns on the flush edge and is simply not written.
    assign wr_en = inflight_q && !flush;

    // Entries already buffered or in flight, less the one leaving this cycle, must
    // leave room for the word this issue will return two edges from now.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == ST_RUN) && pc_legal(fetch_pc_q) && !redirect &&
                       (occupancy < 3'd2);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        rd_ptr_d   = rd_ptr_q ^ pop;
        wr_ptr_d   = wr_ptr_q ^ wr_en;
        count_d    = count_q + {1'b0, wr_en} - {1'b0, pop};

        if (issue) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (flush) begin
            fetch_pc_d = redirect_pc;
            count_d    = 2'd0;
            wr_ptr_d   = rd_ptr_d;
        end

        case (state_q)
            ST_RUN: begin
                state_d = pc_legal(fetch_pc_d) ? ST_RUN : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (flush) begin
                    state_d = pc_legal(fetch_pc_d) ? ST_RUN : ST_DRAIN;
                end else if ((count_q == 2'd0) && !inflight_q) begin
                    state_d = ST_TRAP;
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            if (wr_en) begin
                fifo_data_q[wr_ptr_q] <= i_data;
                fifo_pc_q[wr_ptr_q]   <= req_pc_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table for streaming, stall and
// redirect/trap behaviour, plus hand sequences for async reset and PC wrap fault.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] i_addr;
    logic [31:0] i_data;
    logic [31:0] inst, inst_pc;
    logic        inst_valid, inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        trap;

    logic        reset5;
    logic [13:0] i_addr5;
    logic [31:0] i_data5;
    logic [31:0] inst5, inst_pc5;
    logic        inst_valid5, trap5;
    logic        inst_ready5;
    logic        redirect5;
    logic [31:0] redirect_pc5;

    logic [31:0] mem [4096];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(14)) dut (
        .clk(clk), .reset(reset), .i_addr(i_addr), .i_data(i_data),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .trap(trap)
    );

    fetch_unit #(.RESET_PC(32'h0000_3FF8), .ADDR_W(14)) dut5 (
        .clk(clk), .reset(reset5), .i_addr(i_addr5), .i_data(i_data5),
        .inst(inst5), .inst_pc(inst_pc5), .inst_valid(inst_valid5), .inst_ready(inst_ready5),
        .redirect(redirect5), .redirect_pc(redirect_pc5), .trap(trap5)
    );

    // Synchronous-read ram models
    always @(posedge clk) begin
        i_data  <= mem[i_addr[13:2]];
        i_data5 <= mem[i_addr5[13:2]];
    end

    function automatic logic [31:0] dat(input logic [31:0] pc);
        case (pc)
            32'd0:   return 32'hAAAA_0001;
            32'd4:   return 32'hBBBB_0002;
            32'd8:   return 32'hCCCC_0003;
            32'd12:  return 32'hDDDD_0004;
            default: return 32'hD000_0000 | pc;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_v;
        logic [31:0] exp_pc;
        logic        exp_t;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic rd, input logic [31:0] rpc,
                                input logic v, input logic [31:0] pc, input logic t);
        vec_t x;
        x.ready = rdy; x.redir = rd; x.rpc = rpc;
        x.exp_v = v; x.exp_pc = pc; x.exp_t = t;
        return x;
    endfunction

    // Cycle 0 is the half cycle in which reset is released; outputs sampled 1ns after edges.
    task automatic check_restart(input string tag);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("%s c%0d valid", tag, c), {31'b0, inst_valid}, (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                chk($sformatf("%s c%0d pc", tag, c), inst_pc, 32'(4 * (c - 2)));
                chk($sformatf("%s c%0d inst", tag, c), inst, dat(32'(4 * (c - 2))));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " valid"}, {31'b0, inst_valid}, 32'd0);
        chk({tag, " trap"}, {31'b0, trap}, 32'd0);
        chk({tag, " inst"}, inst, 32'd0);
        chk({tag, " inst_pc"}, inst_pc, 32'd0);
        chk({tag, " i_addr"}, {18'b0, i_addr}, 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        for (int w = 0; w < 4096; w++) mem[w] = dat(32'(w) << 2);

        // Stream, 5-cycle stall, redirect while full, bad redirect, ignored redirect in trap
        vecs.push_back(mk(1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 0, 0, 1, 32'(4 * k), 0));
        for (int k = 0; k < 5; k++) vecs.push_back(mk(0, 0, 0, 1, 32'd16, 0));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 0, 0, 1, 32'(16 + 4 * k), 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'd32, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'd32, 0));
        vecs.push_back(mk(0, 1, 32'h100, 1, 32'd32, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 32'h100, 0));
        vecs.push_back(mk(1, 0, 0, 1, 32'h104, 0));
        vecs.push_back(mk(1, 1, 32'h102, 1, 32'h108, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 32'h0, 0, 0, 1));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 0, 0, 0, 0, 1));

        reset = 1'b0; reset5 = 1'b0;
        inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        inst_ready5 = 1'b1; redirect5 = 1'b0; redirect_pc5 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        chk("reset5 i_addr", {18'b0, i_addr5}, 32'h3FF8);

        reset = 1'b1;
        foreach (vecs[r]) begin
            inst_ready  = vecs[r].ready;
            redirect    = vecs[r].redir;
            redirect_pc = vecs[r].rpc;
            chk($sformatf("row%0d valid", r), {31'b0, inst_valid}, {31'b0, vecs[r].exp_v});
            chk($sformatf("row%0d trap", r), {31'b0, trap}, {31'b0, vecs[r].exp_t});
            if (vecs[r].exp_v) begin
                chk($sformatf("row%0d pc", r), inst_pc, vecs[r].exp_pc);
                chk($sformatf("row%0d inst", r), inst, dat(vecs[r].exp_pc));
            end
            @(posedge clk); #1;
        end
        redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;

        // Async reset from trap state, then mid-stream async reset
        #2 reset = 1'b0;
        #1 check_reset_outputs("async1");
        @(negedge clk); reset = 1'b1;
        check_restart("restart1");
        #2 reset = 1'b0;
        #1 check_reset_outputs("async2");
        @(negedge clk); reset = 1'b1;
        check_restart("restart2");

        // PC runs off the end of the legal window: drain two words then trap
        @(negedge clk); reset5 = 1'b1;
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("wrap c%0d valid", c), {31'b0, inst_valid5}, (c == 2 || c == 3) ? 32'd1 : 32'd0);
            chk($sformatf("wrap c%0d trap", c), {31'b0, trap5}, (c >= 5) ? 32'd1 : 32'd0);
            if (c == 2 || c == 3) begin
                chk($sformatf("wrap c%0d pc", c), inst_pc5, (c == 2) ? 32'h3FF8 : 32'h3FFC);
                chk($sformatf("wrap c%0d inst", c), inst5, dat((c == 2) ? 32'h3FF8 : 32'h3FFC));
            end
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
